// File: rtl/rv32i_stage_sequencer_pkg.sv
// Shared types for the RV32I multi-cycle stage sequencer: stage encoding,
// fault causes and the width of the handshake wait counter.
package rv32i_stage_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    DECODE     = 3'd1,
    EXECUTE    = 3'd2,
    MEM_WAIT   = 3'd3,
    WRITE_BACK = 3'd4,
    HALT       = 3'd5,
    FAULT      = 3'd6
  } stage_t;

  typedef enum logic [1:0] {
    CAUSE_NONE           = 2'd0,
    CAUSE_IFETCH_TIMEOUT = 2'd1,
    CAUSE_MEM_TIMEOUT    = 2'd2
  } fault_cause_t;

  // Wide enough for the largest legal MEM_TIMEOUT (65535).
  localparam int WAIT_W = 16;

endpackage

// File: rtl/rv32i_stage_sequencer_perf_counter.sv
// Enable-gated free-running counter with synchronous reset; wraps silently.
module rv32i_stage_sequencer_perf_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rv32i_stage_sequencer.sv
// Multi-cycle stage sequencer: drives stage strobes and memory requests,
// times out stalled handshakes into a sticky FAULT, and supports debug halt.
module rv32i_stage_sequencer
  import rv32i_stage_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W        = 64,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter bit          RESET_HALTED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifetch_req,
  input  logic             ifetch_ack,
  input  logic             instr_is_ebreak,
  input  logic             instr_is_mem,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic             decode_en,
  output logic             execute_en,
  output logic             wb_en,
  input  logic             halt_req,
  input  logic             resume,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [2:0]       stage,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  localparam logic [WAIT_W-1:0] TIMEOUT   = WAIT_W'(MEM_TIMEOUT);
  localparam stage_t            RST_STAGE = RESET_HALTED ? HALT : FETCH;

  stage_t             r_state;
  fault_cause_t       r_cause;
  logic [WAIT_W-1:0]  r_wait;
  logic               w_cycle_en;
  logic               w_instret_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STAGE;
      r_cause <= CAUSE_NONE;
      r_wait  <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          // An ack on the timeout cycle still wins over the fault.
          if (ifetch_ack) begin
            r_state <= DECODE;
          end else if (r_wait == TIMEOUT) begin
            r_state <= FAULT;
            r_cause <= CAUSE_IFETCH_TIMEOUT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        DECODE: begin
          r_state <= EXECUTE;
        end
        EXECUTE: begin
          if (instr_is_ebreak) begin
            r_state <= HALT;
          end else if (instr_is_mem) begin
            r_state <= MEM_WAIT;
            r_wait  <= '0;
          end else begin
            r_state <= WRITE_BACK;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            r_state <= WRITE_BACK;
          end else if (r_wait == TIMEOUT) begin
            r_state <= FAULT;
            r_cause <= CAUSE_MEM_TIMEOUT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        WRITE_BACK: begin
          // Instruction boundary: the only place a debug halt is honoured.
          if (halt_req) begin
            r_state <= HALT;
          end else begin
            r_state <= FETCH;
            r_wait  <= '0;
          end
        end
        HALT: begin
          if (resume) begin
            r_state <= FETCH;
            r_wait  <= '0;
          end
        end
        FAULT: begin
          r_state <= FAULT;
        end
        default: begin
          r_state <= FETCH;
          r_wait  <= '0;
        end
      endcase
    end
  end

  assign ifetch_req  = (r_state == FETCH);
  assign decode_en   = (r_state == DECODE);
  assign execute_en  = (r_state == EXECUTE);
  assign mem_req     = (r_state == MEM_WAIT);
  assign wb_en       = (r_state == WRITE_BACK);
  assign halted      = (r_state == HALT);
  assign fault       = (r_state == FAULT);
  assign fault_cause = r_cause;
  assign stage       = r_state;

  assign w_cycle_en   = (r_state != HALT) && (r_state != FAULT);
  assign w_instret_en = (r_state == WRITE_BACK);

  rv32i_stage_sequencer_perf_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_cycle_en),
    .o_count (cycle_count)
  );

  rv32i_stage_sequencer_perf_counter #(.W(CNT_W)) u_instret_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_instret_en),
    .o_count (instret_count)
  );

endmodule

// File: tb/tb_rv32i_stage_sequencer.sv
// Directed bench for rv32i_stage_sequencer: a MEM_TIMEOUT=4 instance for the
// main scenarios and a RESET_HALTED instance sharing the same stimulus.
module tb_rv32i_stage_sequencer;

  localparam logic [63:0] S_FETCH = 64'd0, S_DECODE = 64'd1, S_EXECUTE = 64'd2,
                          S_HALT = 64'd5, S_FAULT = 64'd6;

  logic clk = 1'b0;
  logic rst, ifetch_ack, instr_is_ebreak, instr_is_mem, mem_ack, halt_req, resume;

  logic        ifetch_req, mem_req, decode_en, execute_en, wb_en, halted, fault;
  logic [1:0]  fault_cause;
  logic [2:0]  stage;
  logic [63:0] cycle_count, instret_count;

  logic        h_ifetch_req, h_mem_req, h_decode_en, h_execute_en, h_wb_en, h_halted, h_fault;
  logic [1:0]  h_fault_cause;
  logic [2:0]  h_stage;
  logic [63:0] h_cycle_count, h_instret_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32i_stage_sequencer #(.CNT_W(64), .MEM_TIMEOUT(4), .RESET_HALTED(1'b0)) dut (
    .clk(clk), .rst(rst),
    .ifetch_req(ifetch_req), .ifetch_ack(ifetch_ack),
    .instr_is_ebreak(instr_is_ebreak), .instr_is_mem(instr_is_mem),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .decode_en(decode_en), .execute_en(execute_en), .wb_en(wb_en),
    .halt_req(halt_req), .resume(resume), .halted(halted), .fault(fault),
    .fault_cause(fault_cause), .stage(stage),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  rv32i_stage_sequencer #(.CNT_W(64), .MEM_TIMEOUT(255), .RESET_HALTED(1'b1)) dut_h (
    .clk(clk), .rst(rst),
    .ifetch_req(h_ifetch_req), .ifetch_ack(ifetch_ack),
    .instr_is_ebreak(instr_is_ebreak), .instr_is_mem(instr_is_mem),
    .mem_req(h_mem_req), .mem_ack(mem_ack),
    .decode_en(h_decode_en), .execute_en(h_execute_en), .wb_en(h_wb_en),
    .halt_req(halt_req), .resume(resume), .halted(h_halted), .fault(h_fault),
    .fault_cause(h_fault_cause), .stage(h_stage),
    .cycle_count(h_cycle_count), .instret_count(h_instret_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int wb_cnt, wb_bad, mem_cyc, wb_at, n;

    rst = 1'b1; ifetch_ack = 1'b0; instr_is_ebreak = 1'b0; instr_is_mem = 1'b0;
    mem_ack = 1'b0; halt_req = 1'b0; resume = 1'b0;
    tick();
    do_reset();

    // Reset state
    check_eq("rst_stage", 64'(stage), S_FETCH);
    check_eq("rst_strobes", 64'({decode_en, execute_en, wb_en, mem_req}), 64'd0);
    check_eq("rst_cycle", cycle_count, 64'd0);
    check_eq("rst_instret", instret_count, 64'd0);
    check_eq("rst_cause", 64'(fault_cause), 64'd0);
    check_eq("rsth_halted", 64'(h_halted), 64'd1);
    check_eq("rsth_stage", 64'(h_stage), S_HALT);

    // Zero-wait ALU stream: 10 instructions in 40 cycles
    ifetch_ack = 1'b1;
    wb_cnt = 0; wb_bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (wb_en) begin
        wb_cnt++;
        if ((i % 4) != 3) wb_bad++;
      end
      tick();
    end
    check_eq("alu_wb_pulses", 64'(wb_cnt), 64'd10);
    check_eq("alu_wb_phase", 64'(wb_bad), 64'd0);
    check_eq("alu_instret", instret_count, 64'd10);
    check_eq("alu_cycle", cycle_count, 64'd40);
    check_eq("alu_stage", 64'(stage), S_FETCH);
    check_eq("h_cycle_frozen", h_cycle_count, 64'd0);

    // Load with mem_ack on the 4th MEM_WAIT cycle: 8 cycles total
    instr_is_mem = 1'b1;
    mem_cyc = 0; wb_at = -1;
    for (int k = 0; k < 8; k++) begin
      if (mem_req) mem_cyc++;
      if (wb_en) wb_at = k;
      mem_ack = (mem_cyc == 4);
      tick();
    end
    mem_ack = 1'b0; instr_is_mem = 1'b0;
    check_eq("ld_mem_cycles", 64'(mem_cyc), 64'd4);
    check_eq("ld_wb_at", 64'(wb_at), 64'd7);
    check_eq("ld_instret", instret_count, 64'd11);
    check_eq("ld_cycle", cycle_count, 64'd48);
    check_eq("ld_stage", 64'(stage), S_FETCH);

    // EBREAK as third instruction
    do_reset();
    ifetch_ack = 1'b1;
    repeat (8) tick();
    instr_is_ebreak = 1'b1;
    wb_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wb_en) wb_cnt++;
    end
    instr_is_ebreak = 1'b0;
    check_eq("eb_halted", 64'(halted), 64'd1);
    check_eq("eb_stage", 64'(stage), S_HALT);
    check_eq("eb_instret", instret_count, 64'd2);
    check_eq("eb_no_wb", 64'(wb_cnt), 64'd0);
    check_eq("eb_cycle", cycle_count, 64'd11);
    repeat (2) tick();
    check_eq("halt_cycle_frozen", cycle_count, 64'd11);
    resume = 1'b1; tick(); resume = 1'b0;
    check_eq("resume_stage", 64'(stage), S_FETCH);
    check_eq("resume_cycle", cycle_count, 64'd11);
    tick();
    resume = 1'b1; tick(); resume = 1'b0;
    check_eq("resume_ignored", 64'(stage), S_EXECUTE);
    tick(); tick();
    check_eq("post_eb_instret", instret_count, 64'd3);
    check_eq("post_eb_cycle", cycle_count, 64'd15);

    // halt_req raised during MEM_WAIT: load completes, then HALT
    instr_is_mem = 1'b1;
    tick(); tick(); tick();
    halt_req = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("hq_wb", 64'(wb_en), 64'd1);
    tick();
    check_eq("hq_halted", 64'(halted), 64'd1);
    check_eq("hq_instret", instret_count, 64'd4);
    check_eq("hq_cycle", cycle_count, 64'd21);
    resume = 1'b1; tick(); resume = 1'b0;
    check_eq("hq_resume_wins", 64'(stage), S_FETCH);
    instr_is_mem = 1'b0;
    repeat (4) tick();
    check_eq("hq_retaken", 64'(halted), 64'd1);
    check_eq("hq_instret2", instret_count, 64'd5);
    halt_req = 1'b0;
    resume = 1'b1; tick(); resume = 1'b0;
    check_eq("hq_release", 64'(stage), S_FETCH);

    // Reset during MEM_WAIT with a stale mem_ack afterwards
    instr_is_mem = 1'b1;
    tick(); tick(); tick();
    check_eq("rmw_in_mem", 64'(mem_req), 64'd1);
    do_reset();
    mem_ack = 1'b1; ifetch_ack = 1'b0; instr_is_mem = 1'b0;
    check_eq("rmw_stage", 64'(stage), S_FETCH);
    check_eq("rmw_cycle0", cycle_count, 64'd0);
    check_eq("rmwh_halted", 64'(h_halted), 64'd1);
    tick();
    mem_ack = 1'b0;
    check_eq("rmw_stage2", 64'(stage), S_FETCH);
    check_eq("rmw_no_wb", 64'({wb_en, mem_req}), 64'd0);
    check_eq("rmw_instret", instret_count, 64'd0);
    check_eq("rmw_cycle1", cycle_count, 64'd1);

    // Ack on the timeout boundary cycle wins
    do_reset();
    repeat (4) tick();
    check_eq("bnd_still_fetch", 64'(stage), S_FETCH);
    ifetch_ack = 1'b1;
    tick();
    ifetch_ack = 1'b0;
    check_eq("bnd_decode", 64'(stage), S_DECODE);
    check_eq("bnd_no_fault", 64'(fault), 64'd0);
    tick(); tick(); tick();

    // Fetch timeout: FAULT after 5 FETCH cycles
    n = 0;
    while (!fault && n < 20) begin
      tick();
      n++;
    end
    check_eq("ito_latency", 64'(n), 64'd5);
    check_eq("ito_cause", 64'(fault_cause), 64'd1);
    check_eq("ito_cycle", cycle_count, 64'd13);
    check_eq("ito_instret", instret_count, 64'd1);
    ifetch_ack = 1'b1; resume = 1'b1;
    repeat (3) tick();
    ifetch_ack = 1'b0; resume = 1'b0;
    check_eq("ito_sticky", 64'(stage), S_FAULT);
    check_eq("ito_frozen", cycle_count, 64'd13);

    // Memory timeout: cause 2
    do_reset();
    ifetch_ack = 1'b1; instr_is_mem = 1'b1;
    tick(); tick(); tick();
    ifetch_ack = 1'b0;
    n = 0;
    while (!fault && n < 20) begin
      tick();
      n++;
    end
    instr_is_mem = 1'b0;
    check_eq("mto_latency", 64'(n), 64'd5);
    check_eq("mto_cause", 64'(fault_cause), 64'd2);
    check_eq("mto_no_req", 64'(mem_req), 64'd0);
    check_eq("mto_cycle", cycle_count, 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
